// File: rtl/seg_decode_pkg.sv
// Shared constants, code values, FSM state type and one-hot helpers
// for the seven-segment scan decoder.
package seg_decode_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] CODE_DASH    = 4'd10;
   localparam logic [3:0] CODE_BLANK   = 4'd11;
   localparam logic [3:0] CODE_ILLEGAL = 4'd15;

   typedef enum logic {
      ST_IDLE,
      ST_COLLECT
   } state_e;

   function automatic logic onehot4(input logic [3:0] p);
      return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] enc4(input logic [3:0] p);
      logic [1:0] r;
      r = 2'd0;
      unique case (1'b1)
         p[3]:    r = 2'd3;
         p[2]:    r = 2'd2;
         p[1]:    r = 2'd1;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_to_code.sv
// Combinational segment-pattern to digit-code lookup.
// Ports: seg_i (g..a), code_o (0-9, DASH, BLANK, ILLEGAL), illegal_o.
module seg7_to_code
   import seg_decode_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] code_o,
   output logic       illegal_o
);

   always_comb begin
      code_o    = CODE_ILLEGAL;
      illegal_o = 1'b0;
      case (seg_i)
         SEG_0:     code_o = 4'd0;
         SEG_1:     code_o = 4'd1;
         SEG_2:     code_o = 4'd2;
         SEG_3:     code_o = 4'd3;
         SEG_4:     code_o = 4'd4;
         SEG_5:     code_o = 4'd5;
         SEG_6:     code_o = 4'd6;
         SEG_7:     code_o = 4'd7;
         SEG_8:     code_o = 4'd8;
         SEG_9:     code_o = 4'd9;
         SEG_DASH:  code_o = CODE_DASH;
         SEG_BLANK: code_o = CODE_BLANK;
         default:   illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 4-digit 7-seg scan and publishes decoded frames.
// Ports: clk190hz, rst (sync high), pos/seg in; dataBus, dot, dotValid,
// frameDone, errFlag, stale out. SEG_DECODE_STALE_EN enables stale.
module seg_scan_decoder
   import seg_decode_pkg::*;
#(
   parameter int STALE_CYCLES = 16
) (
   input  logic        clk190hz,
   input  logic        rst,
   input  logic [3:0]  pos,
   input  logic [7:0]  seg,
   output logic [15:0] dataBus,
   output logic [1:0]  dot,
   output logic        dotValid,
   output logic        frameDone,
   output logic        errFlag,
   output logic        stale
);

   logic [3:0]  pos_q, pos_prev_q;
   logic [7:0]  seg_q;

   state_e      state_q, state_d;
   logic [3:0]  seen_q, seen_d;
   logic [15:0] shadow_q, shadow_d;
   logic        ferr_q, ferr_d;
   logic        pend_q, pend_d;
   logic        dseen_q, dseen_d;
   logic        dmulti_q, dmulti_d;
   logic [1:0]  didx_q, didx_d;

   logic [15:0] data_q, data_d;
   logic [1:0]  dot_q, dot_d;
   logic        dotv_q, dotv_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [3:0]  code;
   logic        illegal;
   logic        is_oh;
   logic        evt;
   logic        publish;
   logic        fresh;
   logic        dup;
   logic [1:0]  idx;
   logic        dot_lit;

   seg7_to_code u_lut (
      .seg_i     (seg_q[6:0]),
      .code_o    (code),
      .illegal_o (illegal)
   );

   assign is_oh   = onehot4(pos_q);
   assign evt     = is_oh && (pos_q != pos_prev_q);
   assign idx     = enc4(pos_q);
   assign dot_lit = seg_q[7];
   assign publish = (state_q == ST_COLLECT) && (seen_q == 4'hF);
   // A digit arriving in the publish cycle opens the next frame.
   assign fresh   = publish || (state_q == ST_IDLE);
   assign dup     = (seen_q & pos_q) != 4'd0;

   always_comb begin
      state_d  = state_q;
      seen_d   = seen_q;
      shadow_d = shadow_q;
      ferr_d   = ferr_q;
      pend_d   = pend_q;
      dseen_d  = dseen_q;
      dmulti_d = dmulti_q;
      didx_d   = didx_q;
      data_d   = data_q;
      dot_d    = dot_q;
      dotv_d   = dotv_q;
      err_d    = err_q;
      done_d   = 1'b0;

      if (publish) begin
         data_d  = shadow_q;
         dotv_d  = dseen_q & ~dmulti_q;
         dot_d   = dseen_q ? didx_q : 2'd0;
         err_d   = ferr_q | dmulti_q | pend_q;
         done_d  = 1'b1;
         pend_d  = 1'b0;
         state_d = ST_IDLE;
         seen_d  = 4'd0;
      end

      if (!is_oh) begin
         state_d = ST_IDLE;
         seen_d  = 4'd0;
      end else if (evt) begin
         if (fresh || dup) begin
            if (!fresh) pend_d = 1'b1;
            state_d  = ST_COLLECT;
            seen_d   = pos_q;
            shadow_d = 16'd0;
            shadow_d[{idx, 2'b00} +: 4] = code;
            ferr_d   = illegal;
            dseen_d  = dot_lit;
            dmulti_d = 1'b0;
            didx_d   = dot_lit ? idx : 2'd0;
         end else begin
            seen_d = seen_q | pos_q;
            shadow_d[{idx, 2'b00} +: 4] = code;
            ferr_d = ferr_q | illegal;
            if (dot_lit) begin
               if (dseen_q) begin
                  dmulti_d = 1'b1;
               end else begin
                  dseen_d = 1'b1;
                  didx_d  = idx;
               end
            end
         end
      end
   end

   always_ff @(posedge clk190hz) begin
      if (rst) begin
         pos_q      <= 4'd0;
         pos_prev_q <= 4'd0;
         seg_q      <= 8'd0;
         state_q    <= ST_IDLE;
         seen_q     <= 4'd0;
         shadow_q   <= 16'd0;
         ferr_q     <= 1'b0;
         pend_q     <= 1'b0;
         dseen_q    <= 1'b0;
         dmulti_q   <= 1'b0;
         didx_q     <= 2'd0;
         data_q     <= 16'd0;
         dot_q      <= 2'd0;
         dotv_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         pos_q      <= pos;
         pos_prev_q <= pos_q;
         seg_q      <= seg;
         state_q    <= state_d;
         seen_q     <= seen_d;
         shadow_q   <= shadow_d;
         ferr_q     <= ferr_d;
         pend_q     <= pend_d;
         dseen_q    <= dseen_d;
         dmulti_q   <= dmulti_d;
         didx_q     <= didx_d;
         data_q     <= data_d;
         dot_q      <= dot_d;
         dotv_q     <= dotv_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign dataBus   = data_q;
   assign dot       = dot_q;
   assign dotValid  = dotv_q;
   assign frameDone = done_q;
   assign errFlag   = err_q;

`ifdef SEG_DECODE_STALE_EN
   localparam int CW = $clog2(STALE_CYCLES + 1);
   localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES);

   logic [CW-1:0] idle_q;

   always_ff @(posedge clk190hz) begin
      if (rst) begin
         idle_q <= '0;
      end else if (evt) begin
         idle_q <= '0;
      end else if (idle_q != STALE_MAX) begin
         idle_q <= idle_q + 1'b1;
      end
   end

   assign stale = (idle_q == STALE_MAX);
`else
   logic unused_stale_cfg;
   assign unused_stale_cfg = (STALE_CYCLES != 0);
   assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder.
// Frames are queued when driven and checked on frameDone.
module tb_seg_scan_decoder;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  dot;
      logic        dotv;
      logic        err;
   } frame_t;

`ifdef SEG_DECODE_STALE_EN
   localparam logic STALE_ON = 1'b1;
`else
   localparam logic STALE_ON = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  pos;
   logic [7:0]  seg;
   logic [15:0] dataBus;
   logic [1:0]  dot;
   logic        dotValid;
   logic        frameDone;
   logic        errFlag;
   logic        stale;

   frame_t exp_q[$];
   int     cmp;
   int     errs;
   int     frames_seen;
   int     pushed;
   int     fsnap;

   seg_scan_decoder #(.STALE_CYCLES(16)) dut (
      .clk190hz  (clk),
      .rst       (rst),
      .pos       (pos),
      .seg       (seg),
      .dataBus   (dataBus),
      .dot       (dot),
      .dotValid  (dotValid),
      .frameDone (frameDone),
      .errFlag   (errFlag),
      .stale     (stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic dig(input logic [3:0] p, input logic [7:0] s,
                      input int n);
      pos = p;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] dt,
                       input logic dv, input logic e);
      frame_t f;
      f.data = d;
      f.dot  = dt;
      f.dotv = dv;
      f.err  = e;
      exp_q.push_back(f);
      pushed++;
   endtask

   always @(negedge clk) begin
      if (frameDone) begin
         frame_t f;
         frames_seen++;
         chk($sformatf("frame%0d_expected", frames_seen),
             {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            chk($sformatf("frame%0d_data", frames_seen),
                {16'd0, dataBus}, {16'd0, f.data});
            chk($sformatf("frame%0d_dotValid", frames_seen),
                {31'd0, dotValid}, {31'd0, f.dotv});
            chk($sformatf("frame%0d_errFlag", frames_seen),
                {31'd0, errFlag}, {31'd0, f.err});
            if (f.dotv)
               chk($sformatf("frame%0d_dot", frames_seen),
                   {30'd0, dot}, {30'd0, f.dot});
         end
      end
   end

   initial begin
      cmp = 0;
      errs = 0;
      frames_seen = 0;
      pushed = 0;
      rst = 1'b1;
      pos = 4'd0;
      seg = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dataBus", {16'd0, dataBus}, 32'd0);
      chk("rst_dot", {30'd0, dot}, 32'd0);
      chk("rst_dotValid", {31'd0, dotValid}, 32'd0);
      chk("rst_frameDone", {31'd0, frameDone}, 32'd0);
      chk("rst_errFlag", {31'd0, errFlag}, 32'd0);
      chk("rst_stale", {31'd0, stale}, 32'd0);
      rst = 1'b0;
      dig(4'd0, 8'h00, 2);
      chk("idle_frameDone", {31'd0, frameDone}, 32'd0);

      // Basic scan 4321, dot on digit 2, with latency check.
      dig(4'b0001, 8'h06, 3);
      dig(4'b0010, 8'h5B, 3);
      dig(4'b0100, 8'hCF, 3);
      push(16'h4321, 2'd2, 1'b1, 1'b0);
      dig(4'b1000, 8'h66, 1);
      chk("lat_e0", {31'd0, frameDone}, 32'd0);
      dig(4'b1000, 8'h66, 1);
      chk("lat_e1", {31'd0, frameDone}, 32'd0);
      dig(4'b1000, 8'h66, 1);
      chk("lat_e2", {31'd0, frameDone}, 32'd1);
      dig(4'b1000, 8'h66, 1);
      chk("lat_e3", {31'd0, frameDone}, 32'd0);
      dig(4'd0, 8'h00, 2);
      chk("basic_one_frame", frames_seen, 32'd1);

      // All dashes.
      dig(4'b0001, 8'h40, 3);
      dig(4'b0010, 8'h40, 3);
      dig(4'b0100, 8'h40, 3);
      push(16'hAAAA, 2'd0, 1'b0, 1'b0);
      dig(4'b1000, 8'h40, 4);
      dig(4'd0, 8'h00, 2);

      // Repeated position restarts collection and flags the frame.
      fsnap = frames_seen;
      dig(4'b0001, 8'h6D, 3);
      dig(4'b0010, 8'h7D, 3);
      dig(4'b0001, 8'h07, 3);
      dig(4'b0010, 8'h7F, 3);
      dig(4'b0100, 8'h6F, 3);
      push(16'h0987, 2'd0, 1'b0, 1'b1);
      dig(4'b1000, 8'h3F, 4);
      dig(4'd0, 8'h00, 2);
      chk("restart_one_frame", frames_seen - fsnap, 32'd1);

      // Illegal pattern on digit 2.
      dig(4'b0001, 8'h06, 3);
      dig(4'b0010, 8'h5B, 3);
      dig(4'b0100, 8'h12, 3);
      push(16'h3F21, 2'd0, 1'b0, 1'b1);
      dig(4'b1000, 8'h4F, 4);
      dig(4'd0, 8'h00, 2);

      // Two dots (digits 0 and 3).
      dig(4'b0001, 8'h86, 3);
      dig(4'b0010, 8'h5B, 3);
      dig(4'b0100, 8'h4F, 3);
      push(16'h4321, 2'd0, 1'b0, 1'b1);
      dig(4'b1000, 8'hE6, 4);
      dig(4'd0, 8'h00, 2);

      // Blank pos mid-frame discards; outputs hold until next frame.
      fsnap = frames_seen;
      dig(4'b0001, 8'h6D, 3);
      dig(4'b0010, 8'h7D, 3);
      dig(4'd0, 8'h00, 3);
      chk("hold_dataBus", {16'd0, dataBus}, 32'h4321);
      chk("hold_no_frame", frames_seen - fsnap, 32'd0);
      dig(4'b0001, 8'h6F, 3);
      dig(4'b0010, 8'h7F, 3);
      chk("hold_dataBus2", {16'd0, dataBus}, 32'h4321);
      dig(4'b0100, 8'h07, 3);
      push(16'h6789, 2'd0, 1'b0, 1'b0);
      dig(4'b1000, 8'h7D, 4);
      dig(4'd0, 8'h00, 2);
      chk("hold_one_frame", frames_seen - fsnap, 32'd1);

      // Reset during collection abandons the frame.
      fsnap = frames_seen;
      dig(4'b0001, 8'h06, 3);
      dig(4'b0010, 8'h5B, 3);
      dig(4'b0100, 8'h4F, 3);
      rst = 1'b1;
      dig(4'd0, 8'h00, 3);
      rst = 1'b0;
      dig(4'd0, 8'h00, 3);
      chk("rstmid_no_frame", frames_seen - fsnap, 32'd0);
      chk("rstmid_dataBus", {16'd0, dataBus}, 32'd0);

      // Blank+dot on digit 0, dash, 0, 1.
      dig(4'b0001, 8'h80, 3);
      dig(4'b0010, 8'h40, 3);
      dig(4'b0100, 8'h3F, 3);
      push(16'h10AB, 2'd0, 1'b1, 1'b0);
      dig(4'b1000, 8'h06, 4);
      dig(4'd0, 8'h00, 2);

      // Back-to-back frames, one cycle per digit.
      push(16'h4321, 2'd0, 1'b0, 1'b0);
      push(16'h8765, 2'd1, 1'b1, 1'b0);
      dig(4'b0001, 8'h06, 1);
      dig(4'b0010, 8'h5B, 1);
      dig(4'b0100, 8'h4F, 1);
      dig(4'b1000, 8'h66, 1);
      dig(4'b0001, 8'h6D, 1);
      dig(4'b0010, 8'hFD, 1);
      dig(4'b0100, 8'h07, 1);
      dig(4'b1000, 8'h7F, 4);
      dig(4'd0, 8'h00, 2);

      // Stale threshold and release.
      dig(4'b0100, 8'h06, 17);
      chk("stale_before", {31'd0, stale}, 32'd0);
      dig(4'b0100, 8'h06, 1);
      chk("stale_at", {31'd0, stale}, {31'd0, STALE_ON});
      dig(4'b0010, 8'h06, 1);
      chk("stale_hold", {31'd0, stale}, {31'd0, STALE_ON});
      dig(4'b0010, 8'h06, 1);
      chk("stale_clear", {31'd0, stale}, 32'd0);
      dig(4'd0, 8'h00, 5);

      chk("frame_count", frames_seen, pushed);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
